// File: rtl/ov7725_cfg_sequencer.sv
// OV7725 power-up register sequencer: walks the config LUT and issues one
// SCCB write per entry, with NACK retry, inline delay entries and re-trigger.
module ov7725_cfg_sequencer #(
  parameter int         LUT_FIRST  = 3,
  parameter int         LUT_LAST   = 5,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         INIT_DELAY = 1_000_000,
  parameter int         GAP_CYCLES = 500,
  parameter int         DELAY_UNIT = 50_000,
  parameter int         RETRY_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wr_data,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [7:0]  FIRST_IDX = 8'(LUT_FIRST);
  localparam logic [7:0]  LAST_IDX  = 8'(LUT_LAST);
  localparam logic [31:0] INIT_LIM  = 32'(INIT_DELAY - 1);
  localparam logic [31:0] GAP_LIM   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] UNIT      = 32'(DELAY_UNIT);

  if (LUT_LAST > 255 || LUT_LAST < LUT_FIRST || LUT_FIRST < 0) begin : g_bad_range
    $error("ov7725_cfg_sequencer: LUT range must satisfy 0 <= FIRST <= LAST <= 255");
  end

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_DLY,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic          req_q, req_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          again_q, again_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWR_WAIT;
      idx_q   <= FIRST_IDX;
      reg_q   <= '0;
      val_q   <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      retry_q <= '0;
      again_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      again_q <= again_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reg_d   = reg_q;
    val_d   = val_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    again_d = again_q;
    unique case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == INIT_LIM) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: begin
        // reg 0xFF marks a delay entry; its value counts DELAY_UNIT blocks
        if (lut_data[15:8] == 8'hFF) begin
          cnt_d   = 32'(lut_data[7:0]) * UNIT;
          state_d = S_DLY;
        end else begin
          reg_d   = lut_data[15:8];
          val_d   = lut_data[7:0];
          state_d = S_ISSUE;
        end
      end
      S_DLY: begin
        if (cnt_q == '0) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i2c_done) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (!i2c_ack_err) begin
            retry_d = '0;
            again_d = 1'b0;
            state_d = S_GAP;
          end else if (retry_q != RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            again_d = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LIM) begin
          cnt_d = '0;
          if (again_q) begin
            again_d = 1'b0;
            state_d = S_FETCH;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          retry_d = '0;
          again_d = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase
  end

  assign lut_index    = idx_q;
  assign i2c_req      = req_q;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = reg_q;
  assign i2c_wr_data  = val_q;
  assign cfg_done     = (state_q == S_DONE);
  assign cfg_err      = (state_q == S_ERROR);
  assign cfg_busy     = !(cfg_done || cfg_err);

endmodule

// File: tb/tb_ov7725_cfg_sequencer.sv
// Bench for ov7725_cfg_sequencer: ROM + SCCB slave model, expected write
// list derived from the LUT contents and NACK plan, checked every cycle.
module tb_ov7725_cfg_sequencer;
  localparam int INIT = 20;
  localparam int GAP  = 4;
  localparam int UNIT = 10;
  localparam int RMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        i2c_req;
  logic [7:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wr_data;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  ov7725_cfg_sequencer #(
    .LUT_FIRST(3), .LUT_LAST(5), .DEV_ADDR(8'h42),
    .INIT_DELAY(INIT), .GAP_CYCLES(GAP), .DELAY_UNIT(UNIT), .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .lut_index(lut_index), .lut_data(lut_data),
    .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_wr_data(i2c_wr_data),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  int          nack_cnt [256];
  assign lut_data = rom[lut_index];

  typedef struct {
    logic [15:0] rv;
    bit          nack;
    int          min_gap;
  } att_t;

  att_t        exp_q[$];
  logic [15:0] obs_q[$];
  bit          exp_err;
  int          exp_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_n, lat, rst_rel, start_cyc, last_done, max_gap, gap, s_cnt;
  bit first_pend, restart_pend, have_ref, req_prev, s_active, s_nack;
  logic [15:0] cur_rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(string name, longint act, longint lo, longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Expected attempt list from LUT contents and per-entry NACK plan
  task automatic build_model();
    att_t a;
    int pend;
    bit stop;
    exp_q.delete();
    exp_err = 0;
    exp_idx = 5;
    pend = 0;
    stop = 0;
    for (int i = 3; i <= 5 && !stop; i++) begin
      if (rom[i][15:8] == 8'hFF) begin
        pend += int'(rom[i][7:0]) * UNIT;
      end else begin
        for (int k = 0; k <= RMAX; k++) begin
          a.rv = rom[i];
          a.nack = (k < nack_cnt[i]);
          a.min_gap = GAP + pend;
          pend = 0;
          exp_q.push_back(a);
          if (!a.nack) break;
          if (k == RMAX) begin
            exp_err = 1;
            exp_idx = i;
            stop = 1;
          end
        end
      end
    end
  endtask

  // Per-cycle monitor and SCCB slave
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (cyc > 0) begin
          chk("rst_req", i2c_req, 0);
          chk("rst_busy", cfg_busy, 1);
          chk("rst_done", cfg_done, 0);
          chk("rst_err", cfg_err, 0);
          chk("rst_idx", lut_index, 3);
          chk("rst_regval", {i2c_reg_addr, i2c_wr_data}, 0);
        end
        rst_rel = cyc;
        first_pend = 1;
        req_prev = 0;
        s_active = 0;
        have_ref = 0;
        i2c_done = 0;
        i2c_ack_err = 0;
      end else begin
        chk("done_err_excl", cfg_done && cfg_err, 0);
        chk("busy", cfg_busy, !(cfg_done || cfg_err));
        if (i2c_req) begin
          if (!req_prev) begin
            if (first_pend) chk("first_req_lat", cyc - rst_rel, 22);
            first_pend = 0;
            if (restart_pend) chk_rng("restart_lat", cyc - start_cyc, 2, 5);
            restart_pend = 0;
            if (have_ref) begin
              gap = cyc - last_done;
              if (gap > max_gap) max_gap = gap;
            end
            if (wr_n < exp_q.size()) begin
              chk("write", {i2c_reg_addr, i2c_wr_data}, exp_q[wr_n].rv);
              if (have_ref)
                chk_rng("gap", gap, exp_q[wr_n].min_gap, exp_q[wr_n].min_gap + 8);
              s_nack = exp_q[wr_n].nack;
            end else begin
              chk("extra_write", wr_n, exp_q.size());
              s_nack = 0;
            end
            chk("dev_addr", i2c_dev_addr, 8'h42);
            cur_rv = {i2c_reg_addr, i2c_wr_data};
            obs_q.push_back(cur_rv);
            wr_n++;
            s_active = 1;
            s_cnt = lat;
          end else begin
            chk("stable", {i2c_reg_addr, i2c_wr_data}, cur_rv);
          end
          chk("req_in_term", cfg_done || cfg_err, 0);
        end
        if (i2c_done) begin
          last_done = cyc;
          have_ref = 1;
          chk("req_drop", i2c_req, 0);
        end
        req_prev = i2c_req;
        if (i2c_done) begin
          i2c_done = 0;
          i2c_ack_err = 0;
        end else if (s_active) begin
          if (s_cnt == 0) begin
            i2c_done = 1;
            i2c_ack_err = s_nack;
            s_active = 0;
          end else begin
            s_cnt--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prepare_run();
    wr_n = 0;
    obs_q.delete();
    have_ref = 0;
    max_gap = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    prepare_run();
    rst = 0;
  endtask

  task automatic do_start();
    prepare_run();
    restart_pend = (rom[3][15:8] != 8'hFF);
    start_cyc = cyc;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_wr(int n);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (wr_n >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_write: got %0d writes want %0d", wr_n, n);
    end
  endtask

  task automatic wait_end();
    bit fin = 0;
    tick();
    for (int k = 0; k < 20000; k++) begin
      if (cfg_done || cfg_err) begin
        fin = 1;
        break;
      end
      tick();
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%0d err=%0d want finished", cfg_done, cfg_err);
    end
  endtask

  task automatic final_checks();
    chk("end_done", cfg_done, !exp_err);
    chk("end_err", cfg_err, exp_err);
    chk("end_idx", lut_index, exp_idx);
    chk("end_req", i2c_req, 0);
    chk("end_busy", cfg_busy, 0);
    chk("end_count", wr_n, exp_q.size());
  endtask

  task automatic rom_default();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h0000;
      nack_cnt[i] = 0;
    end
    rom[3] = 16'h1100;
    rom[4] = 16'h1246;
    rom[5] = 16'h0cd0;
  endtask

  logic [15:0] lit [3];
  int n1246;

  initial begin
    lit[0] = 16'h1100;
    lit[1] = 16'h1246;
    lit[2] = 16'h0cd0;

    // clean run from reset
    rom_default();
    lat = 8;
    build_model();
    do_reset();
    wait_end();
    final_checks();
    chk("t1_nwr", obs_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < obs_q.size()) chk("t1_write_lit", obs_q[k], lit[k]);
    chk("t1_idx", lut_index, 5);
    chk("t1_done", cfg_done, 1);

    // restart after DONE, with an ignored start during WAIT_DONE
    build_model();
    do_start();
    wait_wr(1);
    start = 1;
    tick();
    start = 0;
    wait_end();
    final_checks();
    chk("t5_nwr", obs_q.size(), 3);

    // entry 4 NACKed twice then ACKed
    nack_cnt[4] = 2;
    build_model();
    do_start();
    wait_end();
    final_checks();
    n1246 = 0;
    foreach (obs_q[k]) if (obs_q[k] == 16'h1246) n1246++;
    chk("t2_n1246", n1246, 3);
    if (obs_q.size() == 5) chk("t2_last", obs_q[4], 16'h0cd0);
    else chk("t2_nwr", obs_q.size(), 5);
    chk("t2_done", cfg_done, 1);

    // entry 4 NACKed four times -> error
    nack_cnt[4] = 4;
    build_model();
    do_start();
    wait_end();
    final_checks();
    n1246 = 0;
    foreach (obs_q[k]) if (obs_q[k] == 16'h1246) n1246++;
    chk("t3_attempts", n1246, 4);
    chk("t3_err", cfg_err, 1);
    chk("t3_done", cfg_done, 0);
    chk("t3_idx", lut_index, 4);
    chk("t3_req", i2c_req, 0);

    // delay entry in slot 4, restarted from ERROR
    nack_cnt[4] = 0;
    rom[4] = 16'hFF03;
    build_model();
    do_start();
    wait_end();
    final_checks();
    chk("t4_nwr", obs_q.size(), 2);
    if (obs_q.size() == 2) chk("t4_second", obs_q[1], 16'h0cd0);
    chk_rng("t4_idle", max_gap, 30, 1000);

    // reset while a request is outstanding
    rom_default();
    build_model();
    do_reset();
    wait_wr(2);
    chk("t6_req_before", i2c_req, 1);
    do_reset();
    wait_end();
    final_checks();
    if (obs_q.size() > 0) chk("t6_first", obs_q[0], 16'h1100);

    // randomized LUT contents, NACK plans and slave latency
    for (int r = 0; r < 10; r++) begin
      for (int i = 3; i <= 5; i++) begin
        if ($urandom_range(0, 4) == 0)
          rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
        else
          rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        nack_cnt[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      lat = int'($urandom_range(0, 12));
      build_model();
      if (r == 5) do_reset();
      else do_start();
      wait_end();
      final_checks();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
